// File: rtl/trace_sequencer.sv
// trace_sequencer: round controller that shows grid trace patterns and credits the first matching player
// Ports: clk/reset (sync, active-high); start begins a round from IDLE or DONE;
//   random_mode/rand_trace/rand_valid pick random patterns; table_addr/table_data read the pattern ROM;
//   player_enable/traced carry per-player drawings; trace_to_display, trace_count, scores, last_winner,
//   clear_traces, busy, game_done and timed_out are registered status outputs.
module trace_sequencer #(
  parameter int TRACE_W = 16,
  parameter int NUM_TRACES = 5,
  parameter int NUM_PLAYERS = 2,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W = $clog2(NUM_TRACES + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           random_mode,
  input  logic [TRACE_W-1:0]             rand_trace,
  input  logic                           rand_valid,
  output logic [CNT_W-1:0]               table_addr,
  input  logic [TRACE_W-1:0]             table_data,
  input  logic [NUM_PLAYERS-1:0]         player_enable,
  input  logic [NUM_PLAYERS*TRACE_W-1:0] traced,
  output logic [TRACE_W-1:0]             trace_to_display,
  output logic [CNT_W-1:0]               trace_count,
  output logic [NUM_PLAYERS*CNT_W-1:0]   scores,
  output logic [NUM_PLAYERS-1:0]         last_winner,
  output logic                           clear_traces,
  output logic                           busy,
  output logic                           game_done,
  output logic                           timed_out
);
  localparam int TMR_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_MATCH, CLEAR, DONE} state_t;
  state_t state;
  logic [TMR_W-1:0] timer;
  logic [NUM_PLAYERS-1:0] match, win;
  logic expire;
  genvar g;
  for (g = 0; g < NUM_PLAYERS; g++) begin : g_match
    assign match[g] = player_enable[g] &
      ((traced[g*TRACE_W +: TRACE_W] & trace_to_display) == trace_to_display);
  end
  // Lowest-index matching player wins ties.
  always_comb begin
    win = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--)
      if (match[i]) win = NUM_PLAYERS'(1) << i;
  end
  assign expire = (TIMEOUT_CYCLES != 0) && (timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign table_addr = trace_count;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      trace_to_display <= '0;
      trace_count <= '0;
      scores <= '0;
      last_winner <= '0;
      clear_traces <= 1'b0;
      busy <= 1'b0;
      game_done <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      clear_traces <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          trace_count <= '0;
          scores <= '0;
          last_winner <= '0;
          timed_out <= 1'b0;
          busy <= 1'b1;
          game_done <= 1'b0;
          state <= LOAD;
        end
        LOAD: if (random_mode) begin
          if (rand_valid && rand_trace != '0) begin
            trace_to_display <= rand_trace;
            timer <= '0;
            state <= WAIT_MATCH;
          end
        end else begin
          trace_to_display <= table_data;
          timer <= '0;
          if (table_data != '0) state <= WAIT_MATCH;
          else begin
            busy <= 1'b0;
            game_done <= 1'b1;
            state <= DONE;
          end
        end
        WAIT_MATCH: if (|match) begin
          for (int i = 0; i < NUM_PLAYERS; i++)
            if (win[i]) scores[i*CNT_W +: CNT_W] <= scores[i*CNT_W +: CNT_W] + CNT_W'(1);
          last_winner <= win;
          trace_count <= trace_count + CNT_W'(1);
          clear_traces <= 1'b1;
          state <= CLEAR;
        end else if (expire) begin
          timed_out <= 1'b1;
          trace_count <= trace_count + CNT_W'(1);
          clear_traces <= 1'b1;
          state <= CLEAR;
        end else timer <= timer + TMR_W'(1);
        CLEAR: if (trace_count == CNT_W'(NUM_TRACES)) begin
          busy <= 1'b0;
          game_done <= 1'b1;
          state <= DONE;
        end else state <= LOAD;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
